// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared controls-bus layout and select resolution helper
package control_pkg;

   localparam int CTRL_W         = 15;
   localparam int CTRL_VALUE_LSB = 0;
   localparam int CTRL_SEL_M     = 9;
   localparam int CTRL_SEL_T     = 10;
   localparam int CTRL_SEL_F     = 11;
   localparam int CTRL_ENTER     = 12;
   localparam int CTRL_MODE_LSB  = 13;

   // One-hot select winner, ordered {f, t, m}; f beats t beats m.
   function automatic logic [2:0] resolve_sel(input logic f, input logic t, input logic m);
      resolve_sel = {f, t & ~f, m & ~f & ~t};
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - 2-FF synchronizer followed by a counting debouncer (1 bit)
module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter bit INVERT          = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic i_raw,
   output logic o_stable
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // Count value at which the next differing cycle completes the window.
   localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_meta;
   logic          r_sync;
   logic          r_stable;
   logic [CW-1:0] r_count;

   // Inversion is applied at the synchronizer input so that a cleared
   // synchronizer reads as "released" rather than as a phantom press.
   // Stable flips only after an unbroken run of differing samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_stable <= 1'b0;
         r_count  <= '0;
      end else begin
         r_meta <= i_raw ^ INVERT;
         r_sync <= r_meta;
         if (r_sync != r_stable) begin
            if (r_count == LP_LAST) begin
               r_stable <= ~r_stable;
               r_count  <= '0;
            end else begin
               r_count <= r_count + 1'b1;
            end
         end else begin
            r_count <= '0;
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/control_conditioner.sv
// rtl/control_conditioner.sv - debounced switches and one-hot button pulses for the mode FSM
module control_conditioner
   import control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        sw_value,
   input  logic [1:0]        sw_mode,
   input  logic              btn_f,
   input  logic              btn_t,
   input  logic              btn_m,
   input  logic              btn_enter,
   output logic [CTRL_W-1:0] controls
);

   // Raw layout: [7:0] value, [9:8] mode, [10] m, [11] t, [12] f, [13] enter.
   logic [13:0]       w_raw;
   logic [13:0]       w_stable;
   logic [3:0]        w_btn;
   logic [3:0]        w_ev;
   logic [2:0]        w_sel;
   logic              w_sel_any;
   logic              w_enter_any;
   logic [CTRL_W-1:0] w_next;

   logic [3:0]        r_btn_d;
   logic              r_enter_pend;
   logic [CTRL_W-1:0] r_controls;

   assign w_raw = {btn_enter, btn_f, btn_t, btn_m, sw_mode, sw_value};

   genvar gi;
   generate
      for (gi = 0; gi < 14; gi++) begin : g_in
         debounce_sync #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (bit'((gi >= 10) && BTN_ACTIVE_LOW))
         ) u_db (
            .clock    (clock),
            .reset    (reset),
            .i_raw    (w_raw[gi]),
            .o_stable (w_stable[gi])
         );
      end
   endgenerate

   // Buttons ordered {enter, f, t, m}; a press event is a stable rising edge.
   assign w_btn = w_stable[13:10];
   assign w_ev  = w_btn & ~r_btn_d;

   // Build the next bus: one select winner, enter deferred while any select fires.
   always_comb begin
      w_sel       = resolve_sel(w_ev[2], w_ev[1], w_ev[0]);
      w_sel_any   = |w_sel;
      w_enter_any = w_ev[3] | r_enter_pend;
      w_next      = '0;
      w_next[CTRL_VALUE_LSB +: 8] = w_stable[7:0];
      w_next[CTRL_SEL_M]          = w_sel[0];
      w_next[CTRL_SEL_T]          = w_sel[1];
      w_next[CTRL_SEL_F]          = w_sel[2];
      w_next[CTRL_ENTER]          = w_enter_any & ~w_sel_any;
      w_next[CTRL_MODE_LSB +: 2]  = w_stable[9:8];
   end

   // Register the bus, edge-detect history and any enter held back by a select.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_btn_d      <= '0;
         r_enter_pend <= 1'b0;
         r_controls   <= '0;
      end else begin
         r_btn_d      <= w_btn;
         r_enter_pend <= w_enter_any & w_sel_any;
         r_controls   <= w_next;
      end
   end

   assign controls = r_controls;

endmodule

// File: tb/tb_control_conditioner.sv
// tb/tb_control_conditioner.sv - directed self-checking bench for control_conditioner
module tb_control_conditioner;

   logic        clock;
   logic        reset;
   logic [7:0]  sw_value;
   logic [1:0]  sw_mode;
   logic        btn_f;
   logic        btn_t;
   logic        btn_m;
   logic        btn_enter;
   logic [14:0] controls;

   int total;
   int bad;

   control_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .sw_value  (sw_value),
      .sw_mode   (sw_mode),
      .btn_f     (btn_f),
      .btn_t     (btn_t),
      .btn_m     (btn_m),
      .btn_enter (btn_enter),
      .controls  (controls)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      sw_value  = 8'h00;
      sw_mode   = 2'b00;
      btn_f     = 1'b1;
      btn_t     = 1'b1;
      btn_m     = 1'b1;
      btn_enter = 1'b1;
   endtask

   // Edge k after the stimulus change: pulse v1 at edge p1, v2 at edge p2, else zero.
   task automatic watch(input string tag, input int n, input int p1, input logic [14:0] v1,
                        input int p2, input logic [14:0] v2);
      logic [14:0] exp;
      for (int k = 0; k < n; k++) begin
         tick();
         exp = (k == p1) ? v1 : ((k == p2) ? v2 : 15'h0000);
         chk($sformatf("%s_e%0d", tag, k), controls, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      idle_inputs();

      // Reset held for 3 cycles while every raw input toggles.
      for (int i = 0; i < 3; i++) begin
         sw_value  = (i % 2 == 0) ? 8'hFF : 8'h00;
         sw_mode   = (i % 2 == 0) ? 2'b11 : 2'b00;
         btn_f     = i[0];
         btn_t     = i[0];
         btn_m     = i[0];
         btn_enter = i[0];
         tick();
         chk($sformatf("reset_c%0d", i), controls, 15'h0000);
      end
      idle_inputs();
      reset = 1'b0;
      watch("post_reset", 10, -1, 15'h0, -1, 15'h0);

      // btn_f press held 50 cycles: one sel_f pulse at edge 6; release is silent.
      btn_f = 1'b0;
      watch("press_f", 50, 6, 15'h0800, -1, 15'h0);
      btn_f = 1'b1;
      watch("release_f", 12, -1, 15'h0, -1, 15'h0);

      // btn_t bounces every 2 cycles for 12 cycles, then settles pressed.
      for (int i = 0; i < 6; i++) begin
         btn_t = i[0];
         tick();
         chk($sformatf("bounce_t_a%0d", i), controls, 15'h0000);
         tick();
         chk($sformatf("bounce_t_b%0d", i), controls, 15'h0000);
      end
      btn_t = 1'b0;
      watch("settle_t", 21, 6, 15'h0400, -1, 15'h0);
      btn_t = 1'b1;
      watch("release_t", 12, -1, 15'h0, -1, 15'h0);

      // Switch fields: value A5, mode 10 -> bits [7:0]=A5, [14:13]=10.
      sw_value = 8'hA5;
      sw_mode  = 2'b10;
      for (int k = 0; k < 13; k++) begin
         tick();
         chk($sformatf("switch_e%0d", k), controls, (k >= 6) ? 15'h40A5 : 15'h0000);
      end
      sw_value = 8'h00;
      sw_mode  = 2'b00;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("switch_clr_e%0d", k), controls, (k >= 6) ? 15'h0000 : 15'h40A5);
      end

      // f and t together: only sel_f fires.
      btn_f = 1'b0;
      btn_t = 1'b0;
      watch("ft", 21, 6, 15'h0800, -1, 15'h0);
      idle_inputs();
      watch("ft_rel", 12, -1, 15'h0, -1, 15'h0);

      // m and enter together: sel_m at edge 6, enter deferred to edge 7.
      btn_m     = 1'b0;
      btn_enter = 1'b0;
      watch("m_enter", 21, 6, 15'h0200, 7, 15'h1000);
      idle_inputs();
      watch("m_enter_rel", 12, -1, 15'h0, -1, 15'h0);

      // All four together: f wins the select, enter follows one edge later.
      btn_f     = 1'b0;
      btn_t     = 1'b0;
      btn_m     = 1'b0;
      btn_enter = 1'b0;
      watch("all4", 21, 6, 15'h0800, 7, 15'h1000);
      idle_inputs();
      watch("all4_rel", 12, -1, 15'h0, -1, 15'h0);

      // Enter alone is not deferred.
      btn_enter = 1'b0;
      watch("enter", 21, 6, 15'h1000, -1, 15'h0);
      idle_inputs();
      watch("enter_rel", 12, -1, 15'h0, -1, 15'h0);

      // Reset mid-debounce: enter press discarded, button released under reset.
      btn_enter = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("midrst_pre_e%0d", k), controls, 15'h0000);
      end
      btn_enter = 1'b1;
      reset     = 1'b1;
      tick();
      chk("midrst_e3", controls, 15'h0000);
      reset = 1'b0;
      watch("midrst_after", 20, -1, 15'h0, -1, 15'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
